// File: rtl/ecc_secded_decoder.sv
// Two-stage Hamming(72,64) SEC-DED decoder with valid/ready flow control and saturating error counters.
// Optional first-error capture log is enabled by defining ECC_DEC_ERR_LOG_EN.
module ecc_secded_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic [7:0]           in_ecc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 single_error,
    output logic                 double_error,
    output logic [6:0]           error_position,
    output logic [7:0]           syndrome,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] ce_count,
    output logic [CNT_WIDTH-1:0] ue_count
`ifdef ECC_DEC_ERR_LOG_EN
    ,
    input  logic                 log_clr,
    output logic                 log_valid,
    output logic                 log_ue,
    output logic [7:0]           log_syndrome,
    output logic [63:0]          log_data
`endif
);

    // Codeword position of each data bit: the non-powers-of-two from 3 upward.
    function automatic logic [63:0][6:0] gen_dpos();
        logic [63:0][6:0] tab;
        int               cnt;
        tab = '0;
        cnt = 0;
        for (int n = 3; n < 72; n++) begin
            if ((n & (n - 1)) != 0) begin
                tab[cnt[5:0]] = 7'(n);
                cnt++;
            end
        end
        return tab;
    endfunction

    function automatic logic [6:0][63:0] gen_mask();
        logic [63:0][6:0] dp;
        logic [6:0][63:0] m;
        dp = gen_dpos();
        m  = '0;
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 7; i++) begin
                m[i][k] = dp[k][i];
            end
        end
        return m;
    endfunction

    localparam logic [63:0][6:0] DPOS  = gen_dpos();
    localparam logic [6:0][63:0] CMASK = gen_mask();

    logic        s1_valid_q, s1_valid_d;
    logic [63:0] s1_data_q, s1_data_d;
    logic [7:0]  s1_syn_q, s1_syn_d;

    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;
    logic [63:0] raw_q, raw_d;
    logic        se_q, se_d;
    logic        de_q, de_d;
    logic [6:0]  pos_q, pos_d;
    logic [7:0]  syn_q, syn_d;

    logic [CNT_WIDTH-1:0] ce_q, ce_d;
    logic [CNT_WIDTH-1:0] ue_q, ue_d;

    logic       s2_free, in_ready_w, fire;
    logic [6:0] s_calc;
    logic       p_calc;
    logic [6:0] s;
    logic [63:0] c_data;
    logic        c_se, c_de;
    logic [6:0]  c_pos;

    assign s2_free    = !out_valid_q || out_ready;
    assign in_ready_w = !s1_valid_q || s2_free;
    assign in_ready   = in_ready_w && !rst;
    assign fire       = out_valid_q && out_ready;
    assign s          = s1_syn_q[6:0];

    always_comb begin
        s_calc = '0;
        for (int i = 0; i < 7; i++) begin
            s_calc[i] = (^(in_data & CMASK[i])) ^ in_ecc[i];
        end
        p_calc = ^{in_data, in_ecc};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        if (in_ready_w) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_syn_d  = {p_calc, s_calc};
            end
        end
    end

    // Classification: odd overall parity means one flipped bit, whose codeword position is s.
    always_comb begin
        c_data = s1_data_q;
        c_se   = 1'b0;
        c_de   = 1'b0;
        c_pos  = '0;
        if (s1_syn_q[7]) begin
            if (s == 7'd0) begin
                c_se  = 1'b1;
                c_pos = 7'd71;
            end else if (s > 7'd71) begin
                c_de = 1'b1;
            end else if ((s & (s - 7'd1)) == 7'd0) begin
                c_se = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    if (s == 7'(1 << i)) c_pos = 7'(64 + i);
                end
            end else begin
                c_se = 1'b1;
                for (int k = 0; k < 64; k++) begin
                    if (DPOS[k] == s) begin
                        c_data[k] = ~s1_data_q[k];
                        c_pos     = 7'(k);
                    end
                end
            end
        end else if (s != 7'd0) begin
            c_de = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        raw_d       = raw_q;
        se_d        = se_q;
        de_d        = de_q;
        pos_d       = pos_q;
        syn_d       = syn_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = c_data;
                raw_d      = s1_data_q;
                se_d       = c_se;
                de_d       = c_de;
                pos_d      = c_pos;
                syn_d      = s1_syn_q;
            end
        end
    end

    // A clear that lands on a counted beat leaves that beat counted.
    always_comb begin
        ce_d = ce_q;
        ue_d = ue_q;
        if (cnt_clr) begin
            ce_d = (fire && se_q) ? CNT_WIDTH'(1) : '0;
            ue_d = (fire && de_q) ? CNT_WIDTH'(1) : '0;
        end else begin
            if (fire && se_q && (ce_q != '1)) ce_d = ce_q + CNT_WIDTH'(1);
            if (fire && de_q && (ue_q != '1)) ue_d = ue_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            raw_q       <= '0;
            se_q        <= 1'b0;
            de_q        <= 1'b0;
            pos_q       <= '0;
            syn_q       <= '0;
            ce_q        <= '0;
            ue_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            raw_q       <= raw_d;
            se_q        <= se_d;
            de_q        <= de_d;
            pos_q       <= pos_d;
            syn_q       <= syn_d;
            ce_q        <= ce_d;
            ue_q        <= ue_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign single_error   = se_q;
    assign double_error   = de_q;
    assign error_position = pos_q;
    assign syndrome       = syn_q;
    assign ce_count       = ce_q;
    assign ue_count       = ue_q;

`ifdef ECC_DEC_ERR_LOG_EN
    logic        log_valid_q, log_valid_d;
    logic        log_ue_q, log_ue_d;
    logic [7:0]  log_syn_q, log_syn_d;
    logic [63:0] log_data_q, log_data_d;
    logic        log_cap;

    assign log_cap = fire && (se_q || de_q) && (!log_valid_q || log_clr);

    always_comb begin
        log_valid_d = log_valid_q;
        log_ue_d    = log_ue_q;
        log_syn_d   = log_syn_q;
        log_data_d  = log_data_q;
        if (log_cap) begin
            log_valid_d = 1'b1;
            log_ue_d    = de_q;
            log_syn_d   = syn_q;
            log_data_d  = raw_q;
        end else if (log_clr) begin
            log_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_valid_q <= 1'b0;
            log_ue_q    <= 1'b0;
            log_syn_q   <= '0;
            log_data_q  <= '0;
        end else begin
            log_valid_q <= log_valid_d;
            log_ue_q    <= log_ue_d;
            log_syn_q   <= log_syn_d;
            log_data_q  <= log_data_d;
        end
    end

    assign log_valid    = log_valid_q;
    assign log_ue       = log_ue_q;
    assign log_syndrome = log_syn_q;
    assign log_data     = log_data_q;
`endif

endmodule

// File: doc/ecc_secded_decoder.md
Name: ecc_secded_decoder

Overview:
- Pipelined Hamming(72,64) SEC-DED decoder/corrector on the DDR5 RCD read-data path.
- Accepts a 64-bit data word plus its 8 received check bits through a valid/ready interface.
- Corrects any single-bit error and flags double or uncorrectable errors.
- Returns the corrected word through a valid/ready interface and keeps saturating correctable/uncorrectable error counters for status reporting.

Parameters:
- CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  decoder can accept a beat.
- in_data  in  64  received data.
- in_ecc  in  8  received check bits; [6:0] Hamming, [7] overall parity.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  64  corrected data.
- single_error  out  1  correctable error in this beat.
- double_error  out  1  uncorrectable error in this beat.
- error_position  out  7  index of the corrected bit.
- syndrome  out  8  {overall parity, s[6:0]} for this beat.
- cnt_clr  in  1  synchronous clear of both counters.
- ce_count  out  CNT_WIDTH  count of accepted beats with single_error.
- ue_count  out  CNT_WIDTH  count of accepted beats with double_error.

Behaviour:
- Reset is asynchronous, active-high. All outputs clear to 0. in_ready is 1 from the first cycle after reset deasserts.
- Code definition:
  - Data bit d[k] occupies codeword position P(k), the k-th non-power-of-2 integer in 3..71 (d0=3, d1=5, d2=6, d3=7, d4=9 ... d56=63, d57=65 ... d63=71).
  - Check bit c[i], i=0..6, sits at position 2^i and is the XOR of all d[k] whose P(k) has bit i set.
  - c[7] is the XOR of all 64 data bits and c[6:0].
- Pipeline:
  - Stage 1 registers the input beat and computes s = recomputed c[6:0] XOR in_ecc[6:0], and p = XOR of all 72 received bits.
  - Stage 2 classifies the beat, corrects the data and drives the outputs.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid with no backpressure. Throughput is 1 beat per clock.
- Classification:
  - s=0, p=0: no error. out_data=in_data, both flags 0, error_position=0.
  - p=1, s=0: single error in c[7]. single_error=1, error_position=71, data unchanged.
  - p=1, s=2^i: single error in check bit c[i]. single_error=1, error_position=64+i, data unchanged.
  - p=1, s equals P(k): single error in data bit d[k]. d[k] is inverted, single_error=1, error_position=k.
  - p=1, s>71: uncorrectable. double_error=1.
  - p=0, s!=0: double error. double_error=1.
  - In both uncorrectable cases out_data=in_data and error_position=0.
  - single_error and double_error are never both 1.
- Handshake:
  - Each stage advances when it is empty or its downstream stage advances.
  - in_ready = !s1_valid || s1_advance.
  - While out_valid && !out_ready, every output stays stable. No beat is dropped or duplicated under any out_ready pattern.
- Counters:
  - ce_count / ue_count increment only on an out_valid&&out_ready beat carrying the matching flag.
  - Counters saturate at all-ones.
  - cnt_clr=1 sets a counter to 0. If cnt_clr coincides with an increment, the counter becomes 1.
- rst asserted mid-stream flushes both stages. In-flight beats are lost and counters clear.

Optional Feature:
- Macro: ECC_DEC_ERR_LOG_EN.
- When defined, adds these outputs:
  - log_valid (1)
  - log_ue (1)
  - log_syndrome (8)
  - log_data (64)
- Behaviour with the macro:
  - log_* capture the raw received data and syndrome of the first accepted errored beat.
  - log_valid is set by that capture and holds the values until log_clr (1-bit input, also added) or reset.
  - Later errors do not overwrite the log while log_valid=1.
  - log_clr coinciding with a new error captures the new error.
- Without the macro, none of these ports or registers exist.

Test Plan:
- in_data=0, in_ecc=0x00, out_ready=1 -> out_valid 2 cycles later; out_data=0; flags 0; syndrome=0x00.
- in_data=0x20, in_ecc=0x00 -> single_error=1; error_position=5; out_data=0; syndrome=0x8A; ce_count=1.
- in_data=0x3, in_ecc=0x00 -> double_error=1; out_data=0x3; syndrome=0x06; ue_count=1.
- in_data=0, in_ecc=0x80 -> single_error=1, error_position=71, out_data=0. Then in_ecc=0x7F -> double_error=1 (s=127>71).
- 8 back-to-back beats with out_ready toggling 1,0,0,1... -> all 8 beats emerge in order, each exactly once; outputs stable during stalls; in_ready drops only when both stages are full.
- CNT_WIDTH=2, 5 single-error beats -> ce_count saturates at 3. cnt_clr coincident with a 6th error beat -> ce_count=1.
